// File: rtl/period_meter_pkg.sv
// period_meter_pkg
//   Shared definitions for the period meter: FSM state encoding and the
//   default counter width / timeout constants used by the top level.
package period_meter_pkg;

  // IDLE  : no reference rising edge yet, counter parked at zero
  // ARMED : counting clk cycles since the last reference rising edge
  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_t;

  localparam int          DEF_CNT_W   = 32;
  localparam int unsigned DEF_TIMEOUT = 32'd200_000_000;

endpackage

// File: rtl/period_meter_sig_sync_filter.sv
// sig_sync_filter
//   Brings the asynchronous input into the clk domain through a 2-flop
//   synchronizer and optionally removes short pulses.
//   Optional feature macro: PERIOD_METER_GLITCH_FILTER_EN
//     defined   - the clean level changes only after 3 consecutive equal
//                 synchronized samples (pulses under 3 cycles vanish)
//     undefined - the clean level is the synchronizer output
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   sig_in in  raw asynchronous input
//   level  out clean, clk-synchronous level
module sig_sync_filter (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic level
);

  logic s1;
  logic s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
    end
  end

`ifdef PERIOD_METER_GLITCH_FILTER_EN
  // s2 plus its two previous samples form the 3-sample window.
  logic [1:0] hist;
  logic       filt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= 2'b00;
      filt <= 1'b0;
    end else begin
      hist <= {hist[0], s2};
      if ((s2 == hist[0]) && (s2 == hist[1])) begin
        filt <= s2;
      end
    end
  end

  assign level = filt;
`else
  assign level = s2;
`endif

endmodule

// File: rtl/period_meter.sv
// period_meter
//   Measures the period and high time of a slow square wave in clk cycles.
//   Optional feature macro: PERIOD_METER_GLITCH_FILTER_EN (input glitch
//   filter inside sig_sync_filter; adds 3 cycles of latency).
// Ports:
//   clk        in  system clock
//   rst_n      in  asynchronous active-low reset
//   sig_in     in  asynchronous square wave under measurement
//   meas_ack   in  consumer acknowledge, clears meas_valid and overrun
//   period     out cycles between the last two rising edges
//   high_time  out cycles high within that period
//   meas_valid out unacknowledged measurement present
//   overrun    out sticky, measurement overwritten before acknowledge
//   timeout    out sticky, no rising edge for TIMEOUT cycles
//   state_dbg  out FSM state (0 = IDLE, 1 = ARMED)
// Handshake: meas_valid rises with each completed measurement and falls on
//   the clock edge after meas_ack is seen without a new completion; a
//   completion in the same cycle as meas_ack keeps meas_valid high and
//   clears overrun.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int          CNT_W   = DEF_CNT_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             meas_ack,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             overrun,
  output logic             timeout,
  output logic             state_dbg
);

  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] high_cap;
  logic             fell_seen;
  logic             level;
  logic             level_d;
  logic             rise;
  logic             fall;
  logic             complete;

  sig_sync_filter u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_in (sig_in),
    .level  (level)
  );

  assign rise      = level & ~level_d;
  assign fall      = ~level & level_d;
  assign complete  = (state == ARMED) && rise;
  assign state_dbg = (state == ARMED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= '0;
      high_cap   <= '0;
      fell_seen  <= 1'b0;
      level_d    <= 1'b0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      overrun    <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      level_d <= level;

      case (state)
        IDLE: begin
          count <= '0;
          if (rise) begin
            state     <= ARMED;
            count     <= ONE;
            timeout   <= 1'b0;
            fell_seen <= 1'b0;
          end
        end

        ARMED: begin
          if (fall) begin
            high_cap  <= count;
            fell_seen <= 1'b1;
          end
          if (rise) begin
            period    <= count;
            // Without a falling edge in this period the signal stayed high
            // throughout, so the high time is the whole period.
            high_time <= fell_seen ? high_cap : count;
            count     <= ONE;
            fell_seen <= 1'b0;
          end else if (count == TO_VAL) begin
            // Leaving for IDLE here is what keeps the counter from wrapping.
            timeout <= 1'b1;
            state   <= IDLE;
            count   <= '0;
          end else begin
            count <= count + ONE;
          end
        end

        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase

      if (complete) begin
        meas_valid <= 1'b1;
        overrun    <= meas_ack ? 1'b0 : (overrun | meas_valid);
      end else if (meas_ack && meas_valid) begin
        meas_valid <= 1'b0;
        overrun    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter
//   Directed bench for period_meter with CNT_W=16, TIMEOUT=64.
//   Define PERIOD_METER_GLITCH_FILTER_EN for both bench and RTL to cover
//   the filtered build.
module tb_period_meter;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 64;

`ifdef PERIOD_METER_GLITCH_FILTER_EN
  localparam int LAT    = 6;
  localparam int GL_P   = 40;
  localparam int GL_H   = 20;
`else
  localparam int LAT    = 3;
  localparam int GL_P   = 29;
  localparam int GL_H   = 9;
`endif

  logic             clk;
  logic             rst_n;
  logic             sig_in;
  logic             meas_ack;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             overrun;
  logic             timeout;
  logic             state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  period_meter #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sig_in     (sig_in),
    .meas_ack   (meas_ack),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .overrun    (overrun),
    .timeout    (timeout),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Wait n rising edges, leaving the bench 1 ns after the last one.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Start a high phase and wait until the resulting edge is visible.
  task automatic rise();
    sig_in = 1'b1;
    tick(LAT);
  endtask

  // Finish the current high phase and run a low phase.
  task automatic cont(input int h_rem, input int l);
    sig_in = 1'b1;
    tick(h_rem);
    sig_in = 1'b0;
    tick(l);
  endtask

  task automatic ack_pulse();
    meas_ack = 1'b1;
    tick(1);
    meas_ack = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n    = 1'b0;
    sig_in   = 1'b0;
    meas_ack = 1'b0;
    tick(3);
    check_eq("rst_period", 32'(period), 0);
    check_eq("rst_high",   32'(high_time), 0);
    check_eq("rst_valid",  32'(meas_valid), 0);
    check_eq("rst_ovr",    32'(overrun), 0);
    check_eq("rst_to",     32'(timeout), 0);
    check_eq("rst_state",  32'(state_dbg), 0);
    rst_n = 1'b1;
    tick(2);

    // first edge only arms
    rise();
    check_eq("arm_state", 32'(state_dbg), 1);
    check_eq("arm_valid", 32'(meas_valid), 0);
    cont(10 - LAT, 10);

    // 10 high / 10 low
    rise();
    check_eq("sq_period", 32'(period), 20);
    check_eq("sq_high",   32'(high_time), 10);
    check_eq("sq_valid",  32'(meas_valid), 1);
    check_eq("sq_ovr",    32'(overrun), 0);
    cont(10 - LAT, 10);

    // third edge without ack -> overrun
    rise();
    check_eq("ovr_set",    32'(overrun), 1);
    check_eq("ovr_valid",  32'(meas_valid), 1);
    cont(6 - LAT, 12);

    // data tracks the latest measurement
    rise();
    check_eq("trk_period", 32'(period), 18);
    check_eq("trk_high",   32'(high_time), 6);
    check_eq("trk_ovr",    32'(overrun), 1);

    // plain ack clears valid and overrun
    ack_pulse();
    check_eq("ack_valid", 32'(meas_valid), 0);
    check_eq("ack_ovr",   32'(overrun), 0);
    cont(10 - LAT - 1, 10);

    rise();
    check_eq("post_ack_period", 32'(period), 20);
    check_eq("post_ack_valid",  32'(meas_valid), 1);
    cont(8 - LAT, 6);

    // ack coincident with a completing edge
    sig_in = 1'b1;
    tick(LAT - 1);
    meas_ack = 1'b1;
    tick(1);
    meas_ack = 1'b0;
    check_eq("coin_valid",  32'(meas_valid), 1);
    check_eq("coin_ovr",    32'(overrun), 0);
    check_eq("coin_period", 32'(period), 14);
    check_eq("coin_high",   32'(high_time), 8);

    // held low long enough to time out
    cont(10 - LAT, 70);
    check_eq("to_set",    32'(timeout), 1);
    check_eq("to_state",  32'(state_dbg), 0);
    check_eq("to_period", 32'(period), 14);
    check_eq("to_valid",  32'(meas_valid), 1);

    ack_pulse();
    check_eq("to_sticky_ack", 32'(timeout), 1);
    check_eq("to_ack_valid",  32'(meas_valid), 0);

    // next rising edge clears timeout and only re-arms
    rise();
    check_eq("to_clr",       32'(timeout), 0);
    check_eq("rearm_state",  32'(state_dbg), 1);
    check_eq("rearm_valid",  32'(meas_valid), 0);
    cont(10 - LAT, 53);

    // period just below the timeout
    rise();
    check_eq("p63_period", 32'(period), 63);
    check_eq("p63_high",   32'(high_time), 10);
    check_eq("p63_to",     32'(timeout), 0);
    check_eq("p63_valid",  32'(meas_valid), 1);

    // asynchronous reset mid-measurement
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_period", 32'(period), 0);
    check_eq("mid_rst_high",   32'(high_time), 0);
    check_eq("mid_rst_valid",  32'(meas_valid), 0);
    check_eq("mid_rst_to",     32'(timeout), 0);
    check_eq("mid_rst_state",  32'(state_dbg), 0);
    sig_in = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(5);
    rise();
    check_eq("rst_arm_valid", 32'(meas_valid), 0);
    check_eq("rst_arm_state", 32'(state_dbg), 1);
    cont(10 - LAT, 10);
    rise();
    check_eq("rst_meas_period", 32'(period), 20);
    check_eq("rst_meas_high",   32'(high_time), 10);

    // 2-cycle low glitch inside a 20-cycle high phase
    cont(9 - LAT, 2);
    rise();
`ifndef PERIOD_METER_GLITCH_FILTER_EN
    check_eq("glitch_spur_period", 32'(period), 11);
    check_eq("glitch_spur_high",   32'(high_time), 9);
`endif
    cont(9 - LAT, 20);
    rise();
    check_eq("glitch_period", 32'(period), GL_P);
    check_eq("glitch_high",   32'(high_time), GL_H);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
